// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-sampled bits, optional parity,
// 1-2 stop bits, single-word holding register with overrun/break flags.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_ready,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = 4;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] LAST_D  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S  = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
  } state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic [1:0]           hist;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_q, par_n;
  logic                 stop_bad, bad_n;
  logic                 any_hi, hi_n;
  logic                 rx_s, maj, tick, xr;
  logic                 done, frame_e, brk, par_e;

  assign rx_s = sync[1];
  assign maj  = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
  assign tick = (cnt == BIT_END);
  assign xr   = (^shreg) ^ par_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync     <= 2'b11;
      hist     <= 2'b11;
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      stop_bad <= 1'b0;
      any_hi   <= 1'b0;
    end else begin
      sync     <= {sync[0], i_rx_serial};
      hist     <= {hist[0], rx_s};
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      stop_bad <= bad_n;
      any_hi   <= hi_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par_q;
    bad_n   = stop_bad;
    hi_n    = any_hi;
    done    = 1'b0;
    frame_e = 1'b0;
    brk     = 1'b0;
    par_e   = 1'b0;
    if (PARITY == 1) par_e = ~xr;
    if (PARITY == 2) par_e = xr;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        bad_n = 1'b0;
        hi_n  = 1'b0;
        par_n = 1'b0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = maj ? S_IDLE : S_DATA;
        end else cnt_n = cnt + 1'b1;
      end
      S_DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shreg_n = {maj, shreg[DATA_BITS-1:1]};
          hi_n    = any_hi | maj;
          if (idx == LAST_D) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end else idx_n = idx + 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      S_PAR: begin
        if (tick) begin
          cnt_n   = '0;
          par_n   = maj;
          hi_n    = any_hi | maj;
          state_n = S_STOP;
        end else cnt_n = cnt + 1'b1;
      end
      S_STOP: begin
        if (tick) begin
          cnt_n = '0;
          if (idx == LAST_S) begin
            done    = 1'b1;
            frame_e = stop_bad | ~maj;
            brk     = ~(any_hi | maj);
            idx_n   = '0;
            state_n = frame_e ? S_WAIT : S_IDLE;
          end else begin
            idx_n = idx + 1'b1;
            bad_n = stop_bad | ~maj;
            hi_n  = any_hi | maj;
          end
        end else cnt_n = cnt + 1'b1;
      end
      S_WAIT: begin
        cnt_n = '0;
        idx_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A finished frame loads only if the holding slot is free or draining now.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_dv      <= 1'b0;
      o_rx_byte    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_rx_dv || i_rx_ready) begin
          o_rx_dv      <= 1'b1;
          o_rx_byte    <= shreg;
          o_parity_err <= par_e;
          o_frame_err  <= frame_e;
          o_break      <= brk;
        end else o_overrun <= 1'b1;
      end else if (o_rx_dv && i_rx_ready) begin
        o_rx_dv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1 and 7E2 instances, queue scoreboard
// popped by a handshake monitor.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct {
    logic [8:0] b;
    logic       p;
    logic       f;
    logic       k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ser_a = 1'b1, rdy_a = 1'b1;
  logic ser_b = 1'b1, rdy_b = 1'b1;
  logic dv_a, pe_a, fe_a, bk_a, ov_a;
  logic dv_b, pe_b, fe_b, bk_b, ov_b;
  logic [7:0] by_a;
  logic [6:0] by_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int ovr_a = 0;
  int ovr_b = 0;
  int words_a = 0;
  int words_b = 0;

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_rx_serial(ser_a), .i_rx_ready(rdy_a),
    .o_rx_dv(dv_a), .o_rx_byte(by_a),
    .o_parity_err(pe_a), .o_frame_err(fe_a),
    .o_break(bk_a), .o_overrun(ov_a)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rx_serial(ser_b), .i_rx_ready(rdy_b),
    .o_rx_dv(dv_b), .o_rx_byte(by_b),
    .o_parity_err(pe_b), .o_frame_err(fe_b),
    .o_break(bk_b), .o_overrun(ov_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ser_a = f[i];
      tick(CPB);
    end
    ser_a = 1'b1;
  endtask

  task automatic send_b(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ser_b = f[i];
      tick(CPB);
    end
    ser_b = 1'b1;
  endtask

  function automatic logic [15:0] fr8(input logic [7:0] d);
    return 16'({1'b1, d, 1'b0});
  endfunction

  function automatic logic [15:0] fr7(input logic [6:0] d,
                                      input logic p,
                                      input logic [1:0] st);
    return 16'({st, p, d, 1'b0});
  endfunction

  task automatic push_a(input logic [7:0] b, input logic p,
                        input logic f, input logic k);
    exp_t e;
    e.b = 9'(b); e.p = p; e.f = f; e.k = k;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [6:0] b, input logic p,
                        input logic f, input logic k);
    exp_t e;
    e.b = 9'(b); e.p = p; e.f = f; e.k = k;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ov_a) ovr_a++;
      if (ov_b) ovr_b++;
      if (dv_a && rdy_a) begin
        words_a++;
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected got %0h want none", by_a);
        end else begin
          ea = qa.pop_front();
          chk("a_byte", 32'(by_a), 32'(ea.b));
          chk("a_flags", 32'({pe_a, fe_a, bk_a}),
              32'({ea.p, ea.f, ea.k}));
        end
      end
      if (dv_b && rdy_b) begin
        words_b++;
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected got %0h want none", by_b);
        end else begin
          eb = qb.pop_front();
          chk("b_byte", 32'(by_b), 32'(eb.b));
          chk("b_flags", 32'({pe_b, fe_b, bk_b}),
              32'({eb.p, eb.f, eb.k}));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int o0, w0;
    logic [7:0] d;
    rst = 1'b1;
    tick(3);
    chk("rst_a", 32'({dv_a, by_a, pe_a, fe_a, bk_a, ov_a}), 0);
    chk("rst_b", 32'({dv_b, by_b, pe_b, fe_b, bk_b, ov_b}), 0);
    rst = 1'b0;
    tick(CPB);

    push_a(8'hA5, 0, 0, 0);
    send_a(fr8(8'hA5), 10);
    tick(CPB);

    push_b(7'h55, 0, 0, 0);
    send_b(fr7(7'h55, 1'b0, 2'b11), 11);
    tick(CPB);
    push_b(7'h55, 1, 0, 0);
    send_b(fr7(7'h55, 1'b1, 2'b11), 11);
    tick(CPB);
    push_b(7'h55, 0, 1, 0);
    send_b(fr7(7'h55, 1'b0, 2'b01), 11);
    tick(CPB);
    push_b(7'h07, 0, 0, 0);
    send_b(fr7(7'h07, 1'b1, 2'b11), 11);
    tick(CPB);

    w0 = words_a;
    push_a(8'h00, 0, 1, 1);
    ser_a = 1'b0;
    tick(20 * CPB);
    ser_a = 1'b1;
    tick(2 * CPB);
    chk("brk_words", 32'(words_a - w0), 1);
    push_a(8'h5A, 0, 0, 0);
    send_a(fr8(8'h5A), 10);
    tick(CPB);

    rdy_a = 1'b0;
    o0 = ovr_a;
    push_a(8'h11, 0, 0, 0);
    send_a(fr8(8'h11), 10);
    tick(CPB);
    send_a(fr8(8'h22), 10);
    tick(CPB);
    chk("ovr_pulse", 32'(ovr_a - o0), 1);
    chk("held", 32'({dv_a, by_a}), 32'({1'b1, 8'h11}));
    rdy_a = 1'b1;
    tick(2);
    chk("dv_fall", 32'(dv_a), 0);

    w0 = words_a;
    ser_a = 1'b0;
    tick(4);
    ser_a = 1'b1;
    tick(3 * CPB);
    chk("glitch", 32'(words_a - w0), 0);

    rdy_a = 1'b0;
    send_a(fr8(8'h66), 10);
    tick(CPB);
    d = 8'h3C;
    ser_a = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      ser_a = d[i];
      tick(CPB);
    end
    ser_a = d[3];
    tick(CPB / 2);
    rst = 1'b1;
    #1;
    chk("mid_rst", 32'({dv_a, by_a, pe_a, fe_a, bk_a, ov_a}), 0);
    ser_a = 1'b1;
    tick(4);
    rst = 1'b0;
    rdy_a = 1'b1;
    tick(CPB);
    push_a(8'h3C, 0, 0, 0);
    send_a(fr8(8'h3C), 10);
    tick(CPB);

    for (int i = 0; i < 50; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      tick(1);
    end
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame: 1 or 2.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port i_rx_serial  input  1  asynchronous serial line; idles high.
REQ-008 SHALL have port i_rx_ready  input  1  consumer accepts held word this cycle.
REQ-009 SHALL have port o_rx_dv  output  1  held word valid; held until accepted.
REQ-010 SHALL have port o_rx_byte  output  DATA_BITS  received data, LSB first on the line.
REQ-011 SHALL have port o_parity_err  output  1  parity mismatch on the held word.
REQ-012 SHALL have port o_frame_err  output  1  stop bit sampled low on the held word.
REQ-013 SHALL have port o_break  output  1  held word is a break: all data, parity and stop samples low.
REQ-014 SHALL have port o_overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass i_rx_serial through a 2-flop synchronizer, reset to 2'b11; all decisions use the synchronized value.
REQ-016 SHALL take each bit sample as the majority of the last 3 synchronized values at the sample point.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE: clear counter and bit index; go to START on synchronized low.
REQ-019 START: at count (CLKS_PER_BIT-1)/2, majority low -> DATA with counter cleared; majority high -> IDLE, treated as a glitch with no output.
REQ-020 DATA: sample every CLKS_PER_BIT clocks into bit index 0..DATA_BITS-1; after the last bit go to PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: sample one bit after CLKS_PER_BIT clocks; odd mode requires the XOR of data and parity bits to be 1, even mode requires it to be 0.
REQ-022 STOP: sample STOP_BITS bits at CLKS_PER_BIT spacing; any low sample is a frame error.
REQ-023 On the clock edge of the final stop sample, the word SHALL complete: load o_rx_byte and flags, assert o_rx_dv, and go to IDLE if no frame error, else WAIT_HIGH.
REQ-024 WAIT_HIGH: stay until a synchronized high is seen, then go to IDLE; a break or stuck-low line never produces a second word.
REQ-025 o_rx_dv SHALL deassert on the edge where o_rx_dv and i_rx_ready are both high; word and flags hold until then.
REQ-026 A word completing while o_rx_dv=1 and i_rx_ready=0 SHALL be dropped and pulse o_overrun for one cycle; the held word is unchanged.
REQ-027 A word completing in the same cycle as an acceptance SHALL replace the held word; o_rx_dv stays 1 and no overrun occurs.
REQ-028 o_break SHALL imply o_frame_err=1.
REQ-029 The counter SHALL be $clog2(CLKS_PER_BIT)+1 bits and SHALL never wrap within a bit period.

Reset
REQ-030 i_rst high SHALL immediately force: state IDLE, counter 0, bit index 0, synchronizer 2'b11, o_rx_dv 0, o_rx_byte 0, all flags 0, o_overrun 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL start only on a fresh falling edge.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-032 Defaults 8N1, send 0xA5 with i_rx_ready=1 -> o_rx_dv high exactly 1 cycle, o_rx_byte=0xA5, all flags 0.
REQ-033 DATA_BITS=7, PARITY=2, STOP_BITS=2: send 0x55 with correct parity -> byte 0x55, no error; flip parity bit -> o_parity_err=1; second stop bit low -> o_frame_err=1.
REQ-034 Hold the line low for 20 bit times -> exactly one word: byte 0, o_break=1, o_frame_err=1; no further words until the line returns high and a new start bit arrives.
REQ-035 With i_rx_ready=0, send 0x11 then 0x22 -> held word 0x11, one o_overrun pulse at completion of 0x22; then raise i_rx_ready -> o_rx_dv falls.
REQ-036 Low glitch of 4 clocks on an idle line -> no o_rx_dv; assert i_rst at data bit 3 of a frame -> all outputs 0; the next full frame 0x3C is received correctly.
